alu_seq: RTL and testbench

//   Registered, handshaked successor of the datapath ALU. It is width-parametrised and adds
//   an iterative multiplier, a signed overflow flag and valid/ready flow control.
//   It sits between register-read and writeback in the multicycle/pipelined core.

---
 rtl/alu_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Registered, handshaked ALU that sits between register-read and writeback.
//   Single-cycle operations (AND, OR, ADD, SUB, SLT, BEQ, BNE) produce their
//   result one cycle after acceptance.  MUL is an iterative shift-and-add
//   multiplier that holds off the issuing stage through in_ready while it runs.
//
//   Build option:
//     ALU_SEQ_MUL_EN  defined   -> aluop 011 runs the iterative multiplier
//                                  (WIDTH+1 cycles from accept to out_valid).
//                     undefined -> no multiplier is built; aluop 011 completes
//                                  in one cycle with result=0, zero=1, ovf=0.
//
//   Parameters:
//     WIDTH      operand/result width in bits (>= 4)
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-high reset
//     in_valid   a, b, aluop valid this cycle
//     in_ready   unit can accept an operation this cycle
//     a, b       operands (WIDTH bits)
//     aluop      000 AND, 001 OR, 010 ADD, 011 MUL, 100 BEQ, 101 BNE,
//                110 SUB, 111 SLT
//     out_valid  result/zero/ovf valid
//     out_ready  consumer takes the result this cycle
//     result     registered result (WIDTH bits)
//     zero       BEQ: a==b, BNE: a!=b, otherwise result==0
//     ovf        signed overflow on ADD/SUB, 0 otherwise
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_BEQ = 3'b100;
  localparam logic [2:0] OP_BNE = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic             accept_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             ovf_r;

  logic             out_valid_nxt_s;
  logic [WIDTH-1:0] result_nxt_s;
  logic             zero_nxt_s;
  logic             ovf_nxt_s;

  // single-cycle datapath
  logic             is_sub_s;
  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_zero_s;
  logic             alu_ovf_s;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

  logic             is_mul_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
`endif

  // Reset gates in_ready so nothing is accepted while the unit is held in reset.
  assign in_ready  = !reset && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;

`ifdef ALU_SEQ_MUL_EN
  assign is_mul_s = (aluop == OP_MUL);
`endif

  // Single-cycle ALU: SUB reuses the adder as a + ~b + 1.
  always_comb begin
    is_sub_s   = (aluop == OP_SUB);
    b_op_s     = is_sub_s ? ~b : b;
    sum_s      = a + b_op_s + {{(WIDTH-1){1'b0}}, is_sub_s};
    alu_res_s  = {WIDTH{1'b0}};
    alu_ovf_s  = 1'b0;
    case (aluop)
      OP_AND: alu_res_s = a & b;
      OP_OR:  alu_res_s = a | b;
      OP_ADD, OP_SUB: begin
        alu_res_s = sum_s;
        alu_ovf_s = (a[WIDTH-1] == b_op_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      // BEQ/BNE return 0 so the result is never X; MUL without the
      // multiplier also lands here and reports result=0, zero=1.
      OP_BEQ, OP_BNE, OP_MUL: alu_res_s = {WIDTH{1'b0}};
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
    if (aluop == OP_BEQ) begin
      alu_zero_s = (a == b);
    end else if (aluop == OP_BNE) begin
      alu_zero_s = (a != b);
    end else begin
      alu_zero_s = (alu_res_s == {WIDTH{1'b0}});
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
`ifdef ALU_SEQ_MUL_EN
        if (accept_s && is_mul_s) begin
          state_nxt_s = ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
`else
        state_nxt_s = ST_IDLE;
`endif
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        if (cnt_r == CNT_DONE) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered result/zero/ovf/out_valid.
  always_comb begin
    out_valid_nxt_s = out_valid_r;
    result_nxt_s    = result_r;
    zero_nxt_s      = zero_r;
    ovf_nxt_s       = ovf_r;
    case (state_r)
      ST_IDLE: begin
`ifdef ALU_SEQ_MUL_EN
        if (accept_s && !is_mul_s) begin
`else
        if (accept_s) begin
`endif
          out_valid_nxt_s = 1'b1;
          result_nxt_s    = alu_res_s;
          zero_nxt_s      = alu_zero_s;
          ovf_nxt_s       = alu_ovf_s;
        end else if (out_ready) begin
          // Also covers accepting a MUL in the same cycle the old result leaves.
          out_valid_nxt_s = 1'b0;
        end else begin
          out_valid_nxt_s = out_valid_r;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        if (cnt_r == CNT_DONE) begin
          out_valid_nxt_s = 1'b1;
          result_nxt_s    = acc_r;
          zero_nxt_s      = (acc_r == {WIDTH{1'b0}});
          ovf_nxt_s       = 1'b0;
        end else begin
          out_valid_nxt_s = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          out_valid_nxt_s = 1'b0;
        end else begin
          out_valid_nxt_s = 1'b1;
        end
      end
      default: out_valid_nxt_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      out_valid_r <= out_valid_nxt_s;
      result_r    <= result_nxt_s;
      zero_r      <= zero_nxt_s;
      ovf_r       <= ovf_nxt_s;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // Shift-and-add multiplier: WIDTH iterations, then one cycle to publish acc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh_r <= {WIDTH{1'b0}};
      b_sh_r <= {WIDTH{1'b0}};
      acc_r  <= {WIDTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else if ((state_r == ST_IDLE) && accept_s && is_mul_s) begin
      a_sh_r <= a;
      b_sh_r <= b;
      acc_r  <= {WIDTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else if ((state_r == ST_MUL) && (cnt_r != CNT_DONE)) begin
      if (b_sh_r[0]) begin
        acc_r <= acc_r + a_sh_r;
      end else begin
        acc_r <= acc_r;
      end
      a_sh_r <= {a_sh_r[WIDTH-2:0], 1'b0};
      b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
      cnt_r  <= cnt_r + CW'(1);
    end else begin
      a_sh_r <= a_sh_r;
      b_sh_r <= b_sh_r;
      acc_r  <= acc_r;
      cnt_r  <= cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//   Directed, self-checking bench for alu_seq (WIDTH=32).  Multiplier
//   scenarios are selected by ALU_SEQ_MUL_EN to match the RTL build.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   aluop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .aluop     (aluop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single edge; in_ready must be high so it is accepted.
  task automatic send(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    aluop    = op;
    a        = x;
    b        = y;
    chk("in_ready_before_send", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] r, input logic z, input logic o);
    chk({tag, "_valid"},  {63'd0, out_valid}, 64'd1);
    chk({tag, "_result"}, {32'd0, result},    {32'd0, r});
    chk({tag, "_zero"},   {63'd0, zero},      {63'd0, z});
    chk({tag, "_ovf"},    {63'd0, ovf},       {63'd0, o});
  endtask

  initial begin
    int  n;
    logic bad;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    aluop     = 3'b000;
    a         = 32'd0;
    b         = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result",    {32'd0, result},    64'd0);
    chk("rst_zero",      {63'd0, zero},      64'd0);
    chk("rst_ovf",       {63'd0, ovf},       64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Arithmetic / compare at latency 1
    send(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    chk_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    send(3'b110, 32'd5, 32'd5);
    chk_out("sub_zero", 32'h0000_0000, 1'b1, 1'b0);
    send(3'b110, 32'h8000_0000, 32'h0000_0001);
    chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
    send(3'b100, 32'h0000_1234, 32'h0000_1234);
    chk_out("beq", 32'h0000_0000, 1'b1, 1'b0);
    send(3'b101, 32'h0000_1234, 32'h0000_1234);
    chk_out("bne", 32'h0000_0000, 1'b0, 1'b0);
    send(3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_out("slt_unsigned", 32'h0000_0000, 1'b1, 1'b0);
    send(3'b111, 32'h0000_0001, 32'hFFFF_FFFF);
    chk_out("slt_true", 32'h0000_0001, 1'b0, 1'b0);

    // Back-to-back stream, consumer always ready
    send(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk_out("stream_and", 32'hF000_F000, 1'b0, 1'b0);
    send(3'b001, 32'hF0F0_0000, 32'h0000_0F0F);
    chk_out("stream_or", 32'hF0F0_0F0F, 1'b0, 1'b0);
    send(3'b010, 32'h0000_0010, 32'h0000_0020);
    chk_out("stream_add", 32'h0000_0030, 1'b0, 1'b0);

    // Backpressure: result held, nothing accepted until consumed
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1;
    aluop    = 3'b001;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0000_0000;
    tick();
    tick();
    chk_out("stall_hold", 32'h0000_0030, 1'b0, 1'b0);
    chk("stall_in_ready2", {63'd0, in_ready}, 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("consumed_valid", {63'd0, out_valid}, 64'd0);
    chk("consumed_in_ready", {63'd0, in_ready}, 64'd1);

    // Reset with a result pending clears the outputs
    send(3'b010, 32'd1, 32'd2);
    chk_out("pre_rst", 32'd3, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_clear_valid",  {63'd0, out_valid}, 64'd0);
    chk("rst_clear_result", {32'd0, result},    64'd0);
    tick();
    reset = 1'b0;
    #1;

`ifdef ALU_SEQ_MUL_EN
    // MUL 0xFFFF * 0x10001 : WIDTH+1 cycles, in_ready low throughout
    send(3'b011, 32'h0000_FFFF, 32'h0001_0001);
    n   = 0;
    bad = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) bad = 1'b1;
      tick();
      n++;
    end
    chk("mul_latency", 64'(n), 64'(W + 1));
    chk("mul_in_ready_low", {63'd0, bad}, 64'd0);
    chk_out("mul_ffff", 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    chk("mul_consumed", {63'd0, out_valid}, 64'd0);

    send(3'b011, 32'h8000_0000, 32'h0000_0002);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("mul2_latency", 64'(n), 64'(W + 1));
    chk_out("mul_wrap", 32'h0000_0000, 1'b1, 1'b0);
    tick();

    // Reset three cycles into MUL 7*9: no stale output afterwards
    send(3'b011, 32'd7, 32'd9);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mulrst_valid",    {63'd0, out_valid}, 64'd0);
    chk("mulrst_result",   {32'd0, result},    64'd0);
    chk("mulrst_in_ready", {63'd0, in_ready},  64'd1);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) bad = 1'b1;
    end
    chk("mulrst_no_stale", {63'd0, bad}, 64'd0);
`else
    // Without the multiplier, aluop 011 completes in one cycle with result 0
    send(3'b011, 32'd3, 32'd4);
    chk_out("mul_disabled", 32'h0000_0000, 1'b1, 1'b0);
    tick();
    chk("mul_disabled_consumed", {63'd0, out_valid}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
